pipeline_stage_decode: RTL and testbench
========================================

# pipeline_stage_decode

Decode stage of the in-order pipeline, consuming the fetch-stage result register and driving `stallOnDecode` back to fetch. Reads source operands from the register file with write-back bypass, detects load-use hazards, squashes wrong-path instructions using the 1-bit PC-change epoch, and registers the result for the execution stage. Latency is one cycle, with one registered output bundle.

## Interface
- `DATA_WIDTH`, 32, operand/PC width
- `REG_ADDR_WIDTH`, 5, register index width
- `PAYLOAD_WIDTH`, 32, opaque decoded-instruction bits, passed through unchanged

- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `fetchValid`  in  1  fetch register holds a real instruction
- `fetchProgramCounter`  in  DATA_WIDTH  PC of fetched instruction
- `fetchEpoch`  in  1  programCounterChangedTimes tag from fetch
- `fetchRs1`, `fetchRs2`, `fetchRd`  in  REG_ADDR_WIDTH  register indices
- `fetchReadsRs1`, `fetchReadsRs2`, `fetchWritesRd`, `fetchIsLoad`  in  1  usage flags
- `fetchPayload`  in  PAYLOAD_WIDTH  passthrough
- `jumpEnabled`  in  1  execution stage redirects PC this cycle
- `stallOnDecode`  out  1  fetch must hold its register and PC
- `regReadAddress1`, `regReadAddress2`  out  REG_ADDR_WIDTH  = fetchRs1/fetchRs2, combinational
- `regReadData1`, `regReadData2`  in  DATA_WIDTH  asynchronous register-file read data
- `writeBackEnabled`  in  1; `writeBackAddress`  in  REG_ADDR_WIDTH; `writeBackData`  in  DATA_WIDTH  write-back port
- `decodeValid`  out  1; `decodeProgramCounter`  out  DATA_WIDTH; `decodeOperand1`, `decodeOperand2`  out  DATA_WIDTH; `decodeRd`  out  REG_ADDR_WIDTH; `decodeWritesRd`, `decodeIsLoad`  out  1; `decodePayload`  out  PAYLOAD_WIDTH  registered result to execution

## Operation
- State: `expectedEpoch` (1 bit) and the output register bundle.
- `expectedEpoch` toggles on every cycle with `jumpEnabled`=1.
- Accept condition: `fetchValid` && `fetchEpoch`==`expectedEpoch` && !`jumpEnabled`. Otherwise the instruction is wrong-path or empty, and a bubble is issued.
- Operand select, per source: index 0 gives 0. A match with `writeBackEnabled` && `writeBackAddress`==index (nonzero) gives `writeBackData`. Else `regReadData`. An unused source (`Reads*`=0) gives 0.
- Load-use hazard: `decodeValid` && `decodeIsLoad` && `decodeWritesRd` && `decodeRd`!=0 && the accepted instruction reads `decodeRd` on either source.
- `stallOnDecode` = hazard && accept condition. It is combinational and never asserted while `jumpEnabled`=1.
- Writes with rd=0 behave as `decodeWritesRd`=0 for hazard purposes. `decodeWritesRd` is output as `fetchWritesRd` && `fetchRd`!=0.
- Next output: on accept && !stall, load all fields from fetch/operands with `decodeValid`=1. Otherwise issue a bubble: `decodeValid`=0, other fields don't-care (implementation drives 0).
- No internal FSM beyond the epoch bit. Stall lasts exactly one cycle per hazard, because the bubble clears `decodeValid`.

## Timing
- Reset (0) immediately sets `decodeValid`=0, all decode fields=0, and `expectedEpoch`=0. `stallOnDecode` is therefore 0 during reset.
- Latency: fetch value at edge N appears on `decode*` after edge N+1.
- On stall at edge N, fetch holds. The bubble is registered, and the same instruction is re-evaluated in cycle N+1 (hazard gone) and accepted at edge N+1.
- Jump at edge N: the output becomes a bubble and the epoch flips. Fetch entries tagged with the old epoch are dropped until the new epoch arrives.
- Jump and hazard in the same cycle: the jump wins, with no stall and a bubble.
- Write-back to the same register in the same cycle as the read: bypass data is used, not stale register-file data.
- Reset deasserted mid-stream: the first edge after release behaves as a normal cycle with `expectedEpoch`=0.

## Test plan
- Reset released with fetch {valid, pc=0x0, epoch 0, rs1=1, regReadData1=0x5}: after 1 edge, `decodeValid`=1, pc=0x0, operand1=0x5.
- Load to rd=3 in decode, next fetch reads rs2=3: `stallOnDecode`=1 for one cycle, one bubble, then the instruction issues with `decodeValid`=1. The same scenario with rd=0 produces no stall.
- Write-back x7=0xDEADBEEF in the same cycle as fetch reads rs1=7 with regReadData1=0x0: operand1=0xDEADBEEF. A read of x0 with write-back to x0 gives 0.
- `jumpEnabled` pulse: the next output is a bubble and `expectedEpoch` becomes 1. Fetch entries with epoch 0 produce bubbles, and the first epoch-1 entry issues.
- Jump coincident with a load-use hazard: `stallOnDecode`=0 and the output is a bubble.
- `reset` asserted while `decodeValid`=1 and a stall is pending: `decodeValid` and `stallOnDecode` drop to 0 without a clock edge.

Source files
------------

// File: rtl/pipeline_stage_decode_if.sv
//==============================================================================
// Module   : pipeline_stage_decode_if
// Brief    : Fetch, register-file, write-back and decode-result signals of the
//            decode stage, with master (pipeline side) and slave (decode) views.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface pipeline_stage_decode_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PAYLOAD_WIDTH  = 32
);
  logic                      fetchValid;
  logic [DATA_WIDTH-1:0]     fetchProgramCounter;
  logic                      fetchEpoch;
  logic [REG_ADDR_WIDTH-1:0] fetchRs1;
  logic [REG_ADDR_WIDTH-1:0] fetchRs2;
  logic [REG_ADDR_WIDTH-1:0] fetchRd;
  logic                      fetchReadsRs1;
  logic                      fetchReadsRs2;
  logic                      fetchWritesRd;
  logic                      fetchIsLoad;
  logic [PAYLOAD_WIDTH-1:0]  fetchPayload;
  logic                      jumpEnabled;
  logic                      stallOnDecode;
  logic [REG_ADDR_WIDTH-1:0] regReadAddress1;
  logic [REG_ADDR_WIDTH-1:0] regReadAddress2;
  logic [DATA_WIDTH-1:0]     regReadData1;
  logic [DATA_WIDTH-1:0]     regReadData2;
  logic                      writeBackEnabled;
  logic [REG_ADDR_WIDTH-1:0] writeBackAddress;
  logic [DATA_WIDTH-1:0]     writeBackData;
  logic                      decodeValid;
  logic [DATA_WIDTH-1:0]     decodeProgramCounter;
  logic [DATA_WIDTH-1:0]     decodeOperand1;
  logic [DATA_WIDTH-1:0]     decodeOperand2;
  logic [REG_ADDR_WIDTH-1:0] decodeRd;
  logic                      decodeWritesRd;
  logic                      decodeIsLoad;
  logic [PAYLOAD_WIDTH-1:0]  decodePayload;

  modport slave (
    input  fetchValid, fetchProgramCounter, fetchEpoch, fetchRs1, fetchRs2,
           fetchRd, fetchReadsRs1, fetchReadsRs2, fetchWritesRd, fetchIsLoad,
           fetchPayload, jumpEnabled, regReadData1, regReadData2,
           writeBackEnabled, writeBackAddress, writeBackData,
    output stallOnDecode, regReadAddress1, regReadAddress2, decodeValid,
           decodeProgramCounter, decodeOperand1, decodeOperand2, decodeRd,
           decodeWritesRd, decodeIsLoad, decodePayload
  );

  modport master (
    output fetchValid, fetchProgramCounter, fetchEpoch, fetchRs1, fetchRs2,
           fetchRd, fetchReadsRs1, fetchReadsRs2, fetchWritesRd, fetchIsLoad,
           fetchPayload, jumpEnabled, regReadData1, regReadData2,
           writeBackEnabled, writeBackAddress, writeBackData,
    input  stallOnDecode, regReadAddress1, regReadAddress2, decodeValid,
           decodeProgramCounter, decodeOperand1, decodeOperand2, decodeRd,
           decodeWritesRd, decodeIsLoad, decodePayload
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_stage_decode.sv
//==============================================================================
// Module   : pipeline_stage_decode
// Brief    : Decode stage: operand read with write-back bypass, load-use stall,
//            epoch-based wrong-path squash, one registered result bundle.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pipeline_stage_decode #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PAYLOAD_WIDTH  = 32
) (
  input  wire logic              clock,
  input  wire logic              reset,
  pipeline_stage_decode_if.slave bus
);

  localparam logic [REG_ADDR_WIDTH-1:0] C_ZERO_REG = '0;

  logic                      epoch_q;
  logic                      valid_q,     valid_d;
  logic [DATA_WIDTH-1:0]     pc_q,        pc_d;
  logic [DATA_WIDTH-1:0]     op1_q,       op1_d;
  logic [DATA_WIDTH-1:0]     op2_q,       op2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
  logic                      writes_rd_q, writes_rd_d;
  logic                      is_load_q,   is_load_d;
  logic [PAYLOAD_WIDTH-1:0]  payload_q,   payload_d;

  logic                  w_accept;
  logic                  w_hazard;
  logic                  w_stall;
  logic [DATA_WIDTH-1:0] w_operand1;
  logic [DATA_WIDTH-1:0] w_operand2;

  assign bus.regReadAddress1 = bus.fetchRs1;
  assign bus.regReadAddress2 = bus.fetchRs2;

  assign w_accept = bus.fetchValid && (bus.fetchEpoch == epoch_q) && !bus.jumpEnabled;

  // Only the registered producer can cause a hazard; a zero destination never writes.
  assign w_hazard = valid_q && is_load_q && writes_rd_q && (rd_q != C_ZERO_REG) &&
                    ((bus.fetchReadsRs1 && (bus.fetchRs1 == rd_q)) ||
                     (bus.fetchReadsRs2 && (bus.fetchRs2 == rd_q)));

  assign w_stall           = w_hazard && w_accept;
  assign bus.stallOnDecode = w_stall;

  always_comb begin
    w_operand1 = '0;
    if (bus.fetchReadsRs1 && (bus.fetchRs1 != C_ZERO_REG)) begin
      if (bus.writeBackEnabled && (bus.writeBackAddress == bus.fetchRs1))
        w_operand1 = bus.writeBackData;
      else
        w_operand1 = bus.regReadData1;
    end
  end

  always_comb begin
    w_operand2 = '0;
    if (bus.fetchReadsRs2 && (bus.fetchRs2 != C_ZERO_REG)) begin
      if (bus.writeBackEnabled && (bus.writeBackAddress == bus.fetchRs2))
        w_operand2 = bus.writeBackData;
      else
        w_operand2 = bus.regReadData2;
    end
  end

  // Bubbles carry all-zero fields so downstream never sees stale data.
  always_comb begin
    valid_d     = 1'b0;
    pc_d        = '0;
    op1_d       = '0;
    op2_d       = '0;
    rd_d        = '0;
    writes_rd_d = 1'b0;
    is_load_d   = 1'b0;
    payload_d   = '0;
    if (w_accept && !w_stall) begin
      valid_d     = 1'b1;
      pc_d        = bus.fetchProgramCounter;
      op1_d       = w_operand1;
      op2_d       = w_operand2;
      rd_d        = bus.fetchRd;
      writes_rd_d = bus.fetchWritesRd && (bus.fetchRd != C_ZERO_REG);
      is_load_d   = bus.fetchIsLoad;
      payload_d   = bus.fetchPayload;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      epoch_q     <= 1'b0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      writes_rd_q <= 1'b0;
      is_load_q   <= 1'b0;
      payload_q   <= '0;
    end else begin
      if (bus.jumpEnabled)
        epoch_q <= ~epoch_q;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      writes_rd_q <= writes_rd_d;
      is_load_q   <= is_load_d;
      payload_q   <= payload_d;
    end
  end

  assign bus.decodeValid          = valid_q;
  assign bus.decodeProgramCounter = pc_q;
  assign bus.decodeOperand1       = op1_q;
  assign bus.decodeOperand2       = op2_q;
  assign bus.decodeRd             = rd_q;
  assign bus.decodeWritesRd       = writes_rd_q;
  assign bus.decodeIsLoad         = is_load_q;
  assign bus.decodePayload        = payload_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_decode.sv
//==============================================================================
// Module   : tb_pipeline_stage_decode
// Brief    : Directed self-checking bench for the decode stage.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pipeline_stage_decode;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  pipeline_stage_decode_if #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .PAYLOAD_WIDTH(32)
  ) bus ();

  pipeline_stage_decode #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .PAYLOAD_WIDTH(32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_fetch();
    bus.fetchValid          = 1'b0;
    bus.fetchProgramCounter = '0;
    bus.fetchEpoch          = 1'b0;
    bus.fetchRs1            = '0;
    bus.fetchRs2            = '0;
    bus.fetchRd             = '0;
    bus.fetchReadsRs1       = 1'b0;
    bus.fetchReadsRs2       = 1'b0;
    bus.fetchWritesRd       = 1'b0;
    bus.fetchIsLoad         = 1'b0;
    bus.fetchPayload        = '0;
    bus.jumpEnabled         = 1'b0;
    bus.regReadData1        = '0;
    bus.regReadData2        = '0;
    bus.writeBackEnabled    = 1'b0;
    bus.writeBackAddress    = '0;
    bus.writeBackData       = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_fetch();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset_valid", bus.decodeValid, 0);
    chk("reset_stall", bus.stallOnDecode, 0);
    chk("reset_pc", bus.decodeProgramCounter, 0);
    chk("reset_op1", bus.decodeOperand1, 0);

    // First instruction after reset release.
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h0; bus.fetchEpoch = 0;
    bus.fetchRs1 = 5'd1; bus.fetchReadsRs1 = 1; bus.regReadData1 = 32'h5;
    bus.fetchPayload = 32'hA5A5_0001;
    tick();
    reset = 1'b1;
    chk("regaddr1", bus.regReadAddress1, 5'd1);
    tick();
    chk("first_valid", bus.decodeValid, 1);
    chk("first_pc", bus.decodeProgramCounter, 32'h0);
    chk("first_op1", bus.decodeOperand1, 32'h5);
    chk("first_payload", bus.decodePayload, 32'hA5A5_0001);

    // Load to x3, then consumer of x3 through rs2.
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h4;
    bus.fetchRd = 5'd3; bus.fetchWritesRd = 1; bus.fetchIsLoad = 1;
    tick();
    chk("load_rd", bus.decodeRd, 5'd3);
    chk("load_isload", bus.decodeIsLoad, 1);
    chk("load_writes", bus.decodeWritesRd, 1);
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h8;
    bus.fetchRs2 = 5'd3; bus.fetchReadsRs2 = 1; bus.regReadData2 = 32'h11;
    #1;
    chk("hazard_stall", bus.stallOnDecode, 1);
    tick();
    chk("hazard_bubble", bus.decodeValid, 0);
    chk("hazard_stall_gone", bus.stallOnDecode, 0);
    tick();
    chk("hazard_issue_valid", bus.decodeValid, 1);
    chk("hazard_issue_pc", bus.decodeProgramCounter, 32'h8);
    chk("hazard_issue_op2", bus.decodeOperand2, 32'h11);

    // Load with rd=0: no stall.
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'hC;
    bus.fetchRd = 5'd0; bus.fetchWritesRd = 1; bus.fetchIsLoad = 1;
    tick();
    chk("rd0_writes", bus.decodeWritesRd, 0);
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h10;
    bus.fetchRs2 = 5'd0; bus.fetchReadsRs2 = 1; bus.regReadData2 = 32'h99;
    #1;
    chk("rd0_no_stall", bus.stallOnDecode, 0);
    tick();
    chk("rd0_valid", bus.decodeValid, 1);
    chk("rd0_op2_zero", bus.decodeOperand2, 0);

    // Write-back bypass, plus an unused source that must read as zero.
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h14;
    bus.fetchRs1 = 5'd7; bus.fetchReadsRs1 = 1; bus.regReadData1 = 32'h0;
    bus.fetchRs2 = 5'd2; bus.fetchReadsRs2 = 0; bus.regReadData2 = 32'h77;
    bus.writeBackEnabled = 1; bus.writeBackAddress = 5'd7; bus.writeBackData = 32'hDEADBEEF;
    tick();
    chk("bypass_op1", bus.decodeOperand1, 32'hDEADBEEF);
    chk("unused_op2", bus.decodeOperand2, 0);
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h18;
    bus.fetchRs1 = 5'd0; bus.fetchReadsRs1 = 1; bus.regReadData1 = 32'h55;
    bus.writeBackEnabled = 1; bus.writeBackAddress = 5'd0; bus.writeBackData = 32'h1234;
    tick();
    chk("x0_bypass_op1", bus.decodeOperand1, 0);

    // Jump pulse: epoch flips to 1, old-epoch entries dropped.
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h1C; bus.fetchEpoch = 0;
    bus.jumpEnabled = 1;
    tick();
    chk("jump_bubble", bus.decodeValid, 0);
    bus.jumpEnabled = 0;
    tick();
    chk("old_epoch_bubble", bus.decodeValid, 0);
    bus.fetchProgramCounter = 32'h20; bus.fetchEpoch = 1;
    tick();
    chk("new_epoch_valid", bus.decodeValid, 1);
    chk("new_epoch_pc", bus.decodeProgramCounter, 32'h20);

    // Jump coincident with load-use hazard.
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h24; bus.fetchEpoch = 1;
    bus.fetchRd = 5'd5; bus.fetchWritesRd = 1; bus.fetchIsLoad = 1;
    tick();
    chk("load2_valid", bus.decodeValid, 1);
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h28; bus.fetchEpoch = 1;
    bus.fetchRs1 = 5'd5; bus.fetchReadsRs1 = 1;
    #1;
    chk("pre_jump_stall", bus.stallOnDecode, 1);
    bus.jumpEnabled = 1;
    #1;
    chk("jump_hazard_no_stall", bus.stallOnDecode, 0);
    tick();
    chk("jump_hazard_bubble", bus.decodeValid, 0);

    // Reset while valid and a stall is pending (epoch now 0).
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h2C; bus.fetchEpoch = 0;
    bus.fetchRd = 5'd6; bus.fetchWritesRd = 1; bus.fetchIsLoad = 1;
    tick();
    chk("load3_valid", bus.decodeValid, 1);
    idle_fetch();
    bus.fetchValid = 1; bus.fetchProgramCounter = 32'h30; bus.fetchEpoch = 0;
    bus.fetchRs1 = 5'd6; bus.fetchReadsRs1 = 1;
    #1;
    chk("pending_stall", bus.stallOnDecode, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_valid", bus.decodeValid, 0);
    chk("async_reset_stall", bus.stallOnDecode, 0);
    chk("async_reset_pc", bus.decodeProgramCounter, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("after_reset_issue", bus.decodeValid, 1);
    chk("after_reset_pc", bus.decodeProgramCounter, 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
